// File: rtl/cpu_bus_sync.sv
// Z80 pin front-end: sync + deglitch control strobes, delay-match a/d, track bus cycles, emit one-shot strobes.
// Controls settle L = SYNC_STAGES + FILTER_LEN edges after the pins; strobes follow one edge later; no backpressure.
module cpu_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic [15:0] cpu_a_raw,
  input  logic [7:0]  cpu_d_raw,
  input  logic        cpu_n_iorq,
  input  logic        cpu_n_mreq,
  input  logic        cpu_n_m1,
  input  logic        cpu_n_rfsh,
  input  logic        cpu_n_rd,
  input  logic        cpu_n_wr,
  output logic [15:0] a,
  output logic [7:0]  d,
  output logic        iorq,
  output logic        mreq,
  output logic        m1,
  output logic        rfsh,
  output logic        rd,
  output logic        wr,
  output logic        ioreq,
  output logic        memreq,
  output logic [15:0] a_reg,
  output logic [7:0]  d_reg,
  output logic        io_rd_stb,
  output logic        io_wr_stb,
  output logic        mem_rd_stb,
  output logic        mem_wr_stb,
  output logic        inta_stb
);

  localparam int LAT  = SYNC_STAGES + FILTER_LEN;
  localparam int NCTL = 6;
  localparam int CW   = 2;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } bus_t;

  typedef enum logic [1:0] {IDLE, MEM, IO, INTA} state_t;

  // Bit order: 5 iorq, 4 mreq, 3 m1, 2 rfsh, 1 rd, 0 wr; inverted on entry so reset (0) means inactive.
  logic [NCTL-1:0] pin_act;
  assign pin_act = ~{cpu_n_iorq, cpu_n_mreq, cpu_n_m1, cpu_n_rfsh, cpu_n_rd, cpu_n_wr};

  logic [SYNC_STAGES-1:0][NCTL-1:0] sync_q;
  logic [NCTL-1:0][CW-1:0]          cnt_q;
  logic [NCTL-1:0]                  filt_q;
  bus_t [LAT-1:0]                   dly_q;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pin_act;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Toggle only after FILTER_LEN consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= '0;
    end else begin
      for (int i = 0; i < NCTL; i++) begin
        if (sync_q[SYNC_STAGES-1][i] != filt_q[i]) begin
          if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
            filt_q[i] <= sync_q[SYNC_STAGES-1][i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= '{a: cpu_a_raw, d: cpu_d_raw};
      for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign a      = dly_q[LAT-1].a;
  assign d      = dly_q[LAT-1].d;
  assign iorq   = filt_q[5];
  assign mreq   = filt_q[4];
  assign m1     = filt_q[3];
  assign rfsh   = filt_q[2];
  assign rd     = filt_q[1];
  assign wr     = filt_q[0];
  assign ioreq  = iorq & ~m1;
  assign memreq = mreq & ~rfsh;

  logic   inta_lvl;
  logic   memreq_q, ioreq_q, inta_q;
  logic   memreq_rise, ioreq_rise, inta_rise;
  logic   req_lvl;
  logic   done_q;
  state_t state_q;

  assign inta_lvl    = iorq & m1;
  assign memreq_rise = memreq & ~memreq_q;
  assign ioreq_rise  = ioreq & ~ioreq_q;
  assign inta_rise   = inta_lvl & ~inta_q;
  assign req_lvl     = (state_q == MEM) ? memreq : iorq;

  // rd/wr act on level with a once-per-bus-cycle latch, so strobes asserted together with the request still fire.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      memreq_q   <= 1'b0;
      ioreq_q    <= 1'b0;
      inta_q     <= 1'b0;
      done_q     <= 1'b0;
      a_reg      <= '0;
      d_reg      <= '0;
      io_rd_stb  <= 1'b0;
      io_wr_stb  <= 1'b0;
      mem_rd_stb <= 1'b0;
      mem_wr_stb <= 1'b0;
      inta_stb   <= 1'b0;
    end else begin
      memreq_q   <= memreq;
      ioreq_q    <= ioreq;
      inta_q     <= inta_lvl;
      io_rd_stb  <= 1'b0;
      io_wr_stb  <= 1'b0;
      mem_rd_stb <= 1'b0;
      mem_wr_stb <= 1'b0;
      inta_stb   <= 1'b0;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (memreq_rise) begin
            state_q <= MEM;
            a_reg   <= a;
          end else if (ioreq_rise) begin
            state_q <= IO;
            a_reg   <= a;
          end else if (inta_rise) begin
            state_q  <= INTA;
            inta_stb <= 1'b1;
          end
        end
        MEM, IO: begin
          if (!req_lvl) begin
            state_q <= IDLE;
          end else if (!done_q && wr) begin
            done_q <= 1'b1;
            d_reg  <= d;
            if (state_q == MEM) mem_wr_stb <= 1'b1;
            else                io_wr_stb  <= 1'b1;
          end else if (!done_q && rd) begin
            done_q <= 1'b1;
            if (state_q == MEM) mem_rd_stb <= 1'b1;
            else                io_rd_stb  <= 1'b1;
          end
        end
        INTA: begin
          if (!iorq) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_bus_sync.md
Name: cpu_bus_sync

Overview:
- Front-end stage feeding the cpu_bus interface.
- Samples the asynchronous raw Z80 pins into the clk28 domain, deglitches the control strobes and converts them to active-high.
- Tracks each bus cycle with a small FSM, latches a_reg and d_reg, and issues one-cycle strobes to downstream port and memory decoders.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per control input; legal range 2..3.
- FILTER_LEN, 2: consecutive identical synced samples required before a control output changes; legal range 1..4.

Ports:
- clk28  in  1  system clock
- rst_n  in  1  async active-low reset
- cpu_a_raw  in  16  Z80 address pins
- cpu_d_raw  in  8  Z80 data pins (input view)
- cpu_n_iorq, cpu_n_mreq, cpu_n_m1, cpu_n_rfsh, cpu_n_rd, cpu_n_wr  in  1 each  raw active-low strobes
- a  out  16  address, delay-matched to controls
- d  out  8  data, delay-matched to controls
- iorq, mreq, m1, rfsh, rd, wr  out  1 each  filtered, active-high
- ioreq  out  1  iorq & ~m1
- memreq  out  1  mreq & ~rfsh
- a_reg  out  16  address latched at request start
- d_reg  out  8  data latched at write
- io_rd_stb, io_wr_stb, mem_rd_stb, mem_wr_stb, inta_stb  out  1 each  single-cycle pulses

Behaviour:
- Reset is asynchronous, active-low: rst_n, clk28 domain. All outputs, synchronizers, filter counters and data delay lines clear to 0. FSM goes to IDLE. Reset asserted mid-cycle aborts the cycle with no strobe. After release, a request already active re-enters through the normal rising-edge path.
- Synchronizer: each cpu_n_* input passes through SYNC_STAGES flops and is inverted.
- Filter: per-signal counter. The output toggles only after FILTER_LEN consecutive synced samples differ from the current output. Any matching sample clears the counter.
- Latency: L = SYNC_STAGES + FILTER_LEN clk28 edges from the first edge sampling the new pin level to the control output change.
- cpu_a_raw and cpu_d_raw are registered and delayed L cycles, so a and d stay aligned with the controls.
- ioreq and memreq are combinational from the filtered outputs.
- FSM states: IDLE, MEM, IO, INTA.
  - IDLE -> MEM on memreq rising edge: a_reg <= a.
  - IDLE -> IO on ioreq rising edge: a_reg <= a.
  - IDLE -> INTA when iorq & m1 rises: inta_stb pulses for one cycle.
  - Simultaneous memreq and ioreq rise: MEM wins, IO ignored until return to IDLE.
- In MEM or IO:
  - wr rising: d_reg <= d, pulse mem_wr_stb or io_wr_stb.
  - rd rising: pulse mem_rd_stb or io_rd_stb; d_reg unchanged.
  - rd and wr rising together: write path only.
  - At most one rd or wr strobe per cycle, even if rd or wr re-toggles.
- Exit: MEM -> IDLE when memreq falls; IO or INTA -> IDLE when iorq falls. If the request falls in the same cycle wr or rd rises, no strobe is issued.
- Strobes and a_reg/d_reg update on the clock edge after the detected filtered edge, i.e. edge L+1.
- rfsh-qualified mreq (refresh) never enters MEM and never strobes. a_reg holds its last value.
- a_reg and d_reg hold between cycles; no wrap or overflow concerns.

Test Plan:
- Memory write, defaults: drive cpu_a_raw=16'h5B00 and cpu_d_raw=8'hA5, then assert mreq, then wr. Required: mreq goes high 4 edges after mreq sampled; a_reg=16'h5B00 on edge 5; mem_wr_stb pulses exactly once; d_reg=8'hA5.
- I/O read of port 16'h7FFD: io_rd_stb pulses once, a_reg=16'h7FFD, io_wr_stb stays 0, d_reg unchanged.
- Glitch rejection: 1-cycle low pulse on cpu_n_iorq. Required: iorq stays 0, no strobes. A 2-cycle pulse (FILTER_LEN=2, pulse outlasting the synchronizer) produces iorq high for 2 cycles.
- Interrupt ack: cpu_n_m1 and cpu_n_iorq low together. Required: inta_stb pulses once, ioreq stays 0, io_*_stb stay 0.
- Refresh: mreq low with rfsh low. Required: memreq=0, no mem strobes, a_reg unchanged from the previous cycle.
- Reset mid-write: pull rst_n low while in MEM with wr low. Required: all outputs 0 immediately. After release with pins idle, a new write strobes normally.
